// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and load-master state type for the core load path.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_t;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WB,
      ST_ERR
   } load_state_t;

   // Core size code 3 has no AHB meaning here; it is issued as a word.
   function automatic logic [2:0] norm_size(input logic [1:0] s);
      return (s == 2'd3) ? 3'(HSIZE_WORD) : {1'b0, s};
   endfunction

   function automatic logic is_misaligned(input logic [1:0] lo, input logic [2:0] sz);
      return ((sz == 3'(HSIZE_HALF)) && lo[0]) ||
             ((sz == 3'(HSIZE_WORD)) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/ahb_load_align.sv
// Little-endian lane extraction of HRDATA with sign/zero extension to 32 bits.
module ahb_load_align
   import ahb_pkg::*;
(
   input  logic [31:0] hrdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = hrdata[7:0];
      case (addr)
         2'd0: byte_lane = hrdata[7:0];
         2'd1: byte_lane = hrdata[15:8];
         2'd2: byte_lane = hrdata[23:16];
         2'd3: byte_lane = hrdata[31:24];
         default: byte_lane = hrdata[7:0];
      endcase
      half_lane = addr[1] ? hrdata[31:16] : hrdata[15:0];
   end

   always_comb begin
      data = hrdata;
      if (size == 3'(HSIZE_BYTE))
         data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      else if (size == 3'(HSIZE_HALF))
         data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
   end

endmodule

// File: rtl/ahb_load_master.sv
// Single-outstanding AHB-Lite load master feeding the register file AHB write port.
// Optional alignment trap on accept: define AHB_LOAD_ALIGN_CHECK_EN.
//
// state   | meaning
// IDLE    | ready for a load request
// ADDR    | NONSEQ address phase, held until HREADY
// DATA    | data phase, waiting for OKAY or first ERROR cycle
// WB      | one-cycle register-file write strobe
// ERR     | waiting for the second ERROR cycle
module ahb_load_master
   import ahb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [4:0]  req_rd,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP,
   output logic        AHB_en_rf,
   output logic [4:0]  AHB_address_write_rf,
   output logic [31:0] ReadData_AHB_rf,
   output logic        flag,
   output logic        err_valid,
   output logic [31:0] err_addr
);

   load_state_t state;
   logic        uns_q;
   logic [4:0]  rd_q;
   logic [31:0] load_data;

   assign HWRITE = 1'b0;
   assign HBURST = HBURST_SINGLE;

   // HADDR/HSIZE double as the latched request address and size.
   ahb_load_align u_align (
      .hrdata      (HRDATA),
      .addr        (HADDR[1:0]),
      .size        (HSIZE),
      .is_unsigned (uns_q),
      .data        (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                <= ST_IDLE;
         req_ready            <= 1'b1;
         HTRANS               <= HTRANS_IDLE;
         HADDR                <= '0;
         HSIZE                <= '0;
         uns_q                <= 1'b0;
         rd_q                 <= '0;
         AHB_en_rf            <= 1'b0;
         AHB_address_write_rf <= '0;
         ReadData_AHB_rf      <= '0;
         flag                 <= 1'b0;
         err_valid            <= 1'b0;
         err_addr             <= '0;
      end else begin
         AHB_en_rf <= 1'b0;
         err_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
`ifdef AHB_LOAD_ALIGN_CHECK_EN
                  if (is_misaligned(req_addr[1:0], norm_size(req_size))) begin
                     err_valid <= 1'b1;
                     err_addr  <= req_addr;
                  end else
`endif
                  begin
                     state     <= ST_ADDR;
                     req_ready <= 1'b0;
                     flag      <= 1'b1;
                     HTRANS    <= HTRANS_NONSEQ;
                     HADDR     <= req_addr;
                     HSIZE     <= norm_size(req_size);
                     uns_q     <= req_unsigned;
                     rd_q      <= req_rd;
                  end
               end
            end
            ST_ADDR: begin
               if (HREADY) begin
                  state  <= ST_DATA;
                  HTRANS <= HTRANS_IDLE;
               end
            end
            ST_DATA: begin
               if (HREADY && !HRESP) begin
                  state                <= ST_WB;
                  ReadData_AHB_rf      <= load_data;
                  AHB_address_write_rf <= rd_q;
                  AHB_en_rf            <= (rd_q != 5'd0);
               end else if (HRESP && !HREADY) begin
                  state <= ST_ERR;
               end else if (HRESP) begin
                  // Malformed single-cycle error: complete it rather than hang.
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  flag      <= 1'b0;
                  err_valid <= 1'b1;
                  err_addr  <= HADDR;
               end
            end
            ST_WB: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               flag      <= 1'b0;
            end
            ST_ERR: begin
               if (HREADY) begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  flag      <= 1'b0;
                  err_valid <= 1'b1;
                  err_addr  <= HADDR;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               flag      <= 1'b0;
               HTRANS    <= HTRANS_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_load_master.sv
// Self-checking bench for ahb_load_master: directed and random loads against a timeline model.
module tb_ahb_load_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [4:0]  req_rd;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic        AHB_en_rf;
   logic [4:0]  AHB_address_write_rf;
   logic [31:0] ReadData_AHB_rf;
   logic        flag;
   logic        err_valid;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ahb_load_master dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_addr             (req_addr),
      .req_size             (req_size),
      .req_unsigned         (req_unsigned),
      .req_rd               (req_rd),
      .HADDR                (HADDR),
      .HTRANS               (HTRANS),
      .HWRITE               (HWRITE),
      .HSIZE                (HSIZE),
      .HBURST               (HBURST),
      .HRDATA               (HRDATA),
      .HREADY               (HREADY),
      .HRESP                (HRESP),
      .AHB_en_rf            (AHB_en_rf),
      .AHB_address_write_rf (AHB_address_write_rf),
      .ReadData_AHB_rf      (ReadData_AHB_rf),
      .flag                 (flag),
      .err_valid            (err_valid),
      .err_addr             (err_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic int size_code(input logic [1:0] sz);
      return (sz == 2'd3) ? 2 : int'(sz);
   endfunction

   function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
      int s;
      s = size_code(sz);
      return (s == 1 && a[0]) || (s == 2 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [1:0] sz,
                                            input logic uns, input logic [31:0] d);
      logic [31:0] v;
      int s;
      s = size_code(sz);
      if (s == 0) begin
         v = (d >> (8 * a[1:0])) & 32'h0000_00FF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (s == 1) begin
         v = (d >> (16 * a[1])) & 32'h0000_FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_htrans"},    32'(HTRANS), 32'd0);
      check({tag, "_haddr"},     HADDR, 32'd0);
      check({tag, "_hsize"},     32'(HSIZE), 32'd0);
      check({tag, "_hwrite"},    32'(HWRITE), 32'd0);
      check({tag, "_hburst"},    32'(HBURST), 32'd0);
      check({tag, "_en_rf"},     32'(AHB_en_rf), 32'd0);
      check({tag, "_rf_addr"},   32'(AHB_address_write_rf), 32'd0);
      check({tag, "_rf_data"},   ReadData_AHB_rf, 32'd0);
      check({tag, "_flag"},      32'(flag), 32'd0);
      check({tag, "_err_valid"}, 32'(err_valid), 32'd0);
      check({tag, "_err_addr"},  err_addr, 32'd0);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   // Cycle c=1 is the cycle after the accepting posedge.
   task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                           input logic [4:0] rd, input int aw, input int dw,
                           input logic [31:0] d, input bit bus_err);
      bit          skip;
      bit          addr_ph;
      bit          ok_load;
      int          cap, wb, last;
      logic [31:0] ed;
      skip = 1'b0;
`ifdef AHB_LOAD_ALIGN_CHECK_EN
      skip = misaligned(a, sz);
`endif
      ok_load = !skip && !bus_err;
      cap  = aw + dw + 2;
      wb   = cap + 1;
      last = skip ? 1 : (bus_err ? cap + 2 : wb + 1);
      ed   = exp_data(a, sz, uns, d);

      req_valid    = 1'b1;
      req_addr     = a;
      req_size     = sz;
      req_unsigned = uns;
      req_rd       = rd;
      HREADY       = 1'b1;
      HRESP        = 1'b0;
      HRDATA       = $urandom;
      @(negedge clk);
      req_valid    = 1'b0;
      req_addr     = $urandom;
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_rd       = 5'($urandom_range(0, 31));

      for (int c = 1; c <= last; c++) begin
         addr_ph = !skip && (c <= aw + 1);
         check("flag",      32'(flag), 32'(c < last));
         check("req_ready", 32'(req_ready), 32'(c >= last));
         check("htrans",    32'(HTRANS), addr_ph ? 32'd2 : 32'd0);
         if (addr_ph) begin
            check("haddr",  HADDR, a);
            check("hsize",  32'(HSIZE), 32'(size_code(sz)));
            check("hwrite", 32'(HWRITE), 32'd0);
            check("hburst", 32'(HBURST), 32'd0);
         end
         check("en_rf",     32'(AHB_en_rf), 32'(ok_load && c == wb && rd != 5'd0));
         check("err_valid", 32'(err_valid), 32'(!ok_load && c == last));
         if (ok_load && rd != 5'd0 && c >= wb) begin
            check("rf_data", ReadData_AHB_rf, ed);
            check("rf_addr", 32'(AHB_address_write_rf), 32'(rd));
         end
         if (!ok_load && c == last)
            check("err_addr", err_addr, a);

         HRDATA = $urandom;
         HRESP  = 1'b0;
         HREADY = 1'b1;
         if (c <= aw)
            HREADY = 1'b0;
         else if (c > aw + 1 && c < cap)
            HREADY = 1'b0;
         else if (c == cap) begin
            if (bus_err) begin
               HREADY = 1'b0;
               HRESP  = 1'b1;
            end else begin
               HRDATA = d;
            end
         end else if (bus_err && c == cap + 1)
            HRESP = 1'b1;
         @(negedge clk);
      end
      HREADY = 1'b1;
      HRESP  = 1'b0;
   endtask

   task automatic reset_mid_data();
      req_valid    = 1'b1;
      req_addr     = 32'h0000_0100;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_rd       = 5'd9;
      HREADY       = 1'b1;
      HRESP        = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_flag",   32'(flag), 32'd1);
      check("mid_htrans", 32'(HTRANS), 32'd0);
      HREADY = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_mid");
      @(negedge clk);
      rst_n  = 1'b1;
      HREADY = 1'b1;
      HRDATA = 32'h1234_5678;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_en",     32'(AHB_en_rf), 32'd0);
         check("post_rst_err",    32'(err_valid), 32'd0);
         check("post_rst_htrans", 32'(HTRANS), 32'd0);
         check("post_rst_flag",   32'(flag), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_addr     = '0;
      req_size     = '0;
      req_unsigned = 1'b0;
      req_rd       = '0;
      HRDATA       = '0;
      HREADY       = 1'b1;
      HRESP        = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_load(32'h0000_0010, 2'd2, 1'b0, 5'd5, 0, 0, 32'hDEAD_BEEF, 1'b0);
      run_load(32'h0000_0013, 2'd0, 1'b0, 5'd7, 0, 0, 32'h8012_3456, 1'b0);
      run_load(32'h0000_0013, 2'd0, 1'b1, 5'd7, 0, 0, 32'h8012_3456, 1'b0);
      run_load(32'h0000_0020, 2'd2, 1'b0, 5'd3, 2, 3, 32'h1234_5678, 1'b0);
      run_load(32'h4000_0000, 2'd2, 1'b0, 5'd4, 0, 0, 32'h0, 1'b1);
      run_load(32'h4000_0000, 2'd2, 1'b0, 5'd4, 1, 2, 32'h0, 1'b1);
      run_load(32'h0000_0030, 2'd1, 1'b0, 5'd0, 0, 0, 32'hFFFF_8000, 1'b0);
      run_load(32'h0000_0032, 2'd1, 1'b0, 5'd10, 0, 0, 32'h8001_7FFF, 1'b0);
      run_load(32'h0000_0012, 2'd2, 1'b0, 5'd6, 0, 0, 32'hCAFE_F00D, 1'b0);
      run_load(32'h0000_0011, 2'd1, 1'b1, 5'd8, 0, 1, 32'hA5C3_9E81, 1'b0);
      run_load(32'h0000_0024, 2'd3, 1'b0, 5'd31, 1, 0, 32'h0BAD_F00D, 1'b0);
      reset_mid_data();
      run_load(32'h0000_0044, 2'd2, 1'b0, 5'd12, 0, 0, 32'h7654_3210, 1'b0);

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         d = $urandom;
         run_load(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3),
                  d, ($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
